att_spi_master: RTL

ATT_SPI_MASTER -- requirements
Module: att_spi_master

---
 rtl/att_spi_if.sv | 34 +++
 rtl/att_spi_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/att_spi_if.sv
// Bundled control and SPI pins between the attenuator register block and att_spi_master.
// The optional att_le signal exists only when ATT_SPI_LE_EN is defined.
interface att_spi_if #(
  parameter int unsigned NCS = 4
) ();
  logic            start;
  logic [31:0]     att_data;
  logic [31:0]     att_csmask;
  logic            soft_rst;
  logic            sclk;
  logic            mosi;
  logic [NCS-1:0]  cs_n;
  logic            busy;
  logic            done;
`ifdef ATT_SPI_LE_EN
  logic            att_le;
`endif

  modport master (
    input  start, att_data, att_csmask, soft_rst,
    output sclk, mosi, cs_n, busy, done
`ifdef ATT_SPI_LE_EN
    , output att_le
`endif
  );

  modport slave (
    output start, att_data, att_csmask, soft_rst,
    input  sclk, mosi, cs_n, busy, done
`ifdef ATT_SPI_LE_EN
    , input att_le
`endif
  );
endinterface

// File: rtl/att_spi_master.sv
// SPI mode-0 master shifting one word MSB-first into the attenuators selected by a CS mask.
// Define ATT_SPI_LE_EN to add a LATCH state driving att_le after chip-select release.
module att_spi_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned NCS       = 4
) (
  input  logic      clk_i,
  input  logic      reset_i,
  att_spi_if.master bus
);

  localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftLo,
    StShiftHi,
    StHold
`ifdef ATT_SPI_LE_EN
    , StLatch
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           div_q, div_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [NCS-1:0]       mask_q, mask_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic [NCS-1:0]       cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef ATT_SPI_LE_EN
  logic                 le_q, le_d;
`endif

  logic div_last;
  logic bit_last;
  logic unused_inputs;

  assign div_last      = (div_q == 8'(CLK_DIV - 1));
  assign bit_last      = (bit_q == BitW'(DATA_BITS - 1));
  assign unused_inputs = ^{bus.att_data, bus.att_csmask};

  // Next-state: the divider free-runs in every active state and wraps on each phase boundary.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    mask_d  = mask_q;
    div_d   = (state_q == StIdle || div_last) ? 8'd0 : div_q + 8'd1;

    unique case (state_q)
      StIdle: begin
        // A start in the done cycle is dropped; only a settled idle accepts work.
        if (bus.start && !bus.soft_rst && !done_q) begin
          shreg_d = bus.att_data[DATA_BITS-1:0];
          mask_d  = bus.att_csmask[NCS-1:0];
          bit_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (mask_q == '0) begin
          state_d = StIdle;
        end else if (div_last) begin
          state_d = StShiftLo;
        end
      end
      StShiftLo: begin
        if (div_last) state_d = StShiftHi;
      end
      StShiftHi: begin
        if (div_last) begin
          if (bit_last) begin
            state_d = StHold;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q << 1;
            state_d = StShiftLo;
          end
        end
      end
      StHold: begin
`ifdef ATT_SPI_LE_EN
        if (div_last) state_d = StLatch;
`else
        if (div_last) state_d = StIdle;
`endif
      end
`ifdef ATT_SPI_LE_EN
      StLatch: begin
        if (div_last) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (bus.soft_rst) begin
      state_d = StIdle;
      bit_d   = '0;
      div_d   = 8'd0;
    end
  end

  // Outputs are registered from the next state so pins change together with the FSM.
  always_comb begin
    sclk_d = 1'b0;
    mosi_d = 1'b0;
    cs_n_d = '1;
    busy_d = (state_d != StIdle);
    done_d = (state_q != StIdle) && (state_d == StIdle) && !bus.soft_rst;
`ifdef ATT_SPI_LE_EN
    le_d   = 1'b0;
`endif
    unique case (state_d)
      StSetup, StShiftLo, StShiftHi: begin
        cs_n_d = ~mask_d;
        mosi_d = (|mask_d) & shreg_d[DATA_BITS-1];
        sclk_d = (state_d == StShiftHi);
      end
      StHold: begin
        cs_n_d = ~mask_d;
        mosi_d = mosi_q;
      end
`ifdef ATT_SPI_LE_EN
      StLatch: le_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      div_q   <= 8'd0;
      bit_q   <= '0;
      shreg_q <= '0;
      mask_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ATT_SPI_LE_EN
      le_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      mask_q  <= mask_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ATT_SPI_LE_EN
      le_q    <= le_d;
`endif
    end
  end

  assign bus.sclk = sclk_q;
  assign bus.mosi = mosi_q;
  assign bus.cs_n = cs_n_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef ATT_SPI_LE_EN
  assign bus.att_le = le_q;
`endif

endmodule
